// File: rtl/avalon_pio_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : avalon_pio_master
// Description : Avalon-MM master for single write/read transfers to PIO
//               slaves. A command/response handshake lets hardware control
//               logic drive actuator PIO registers without a soft CPU.
//               Optional macro PIO_READBACK_VERIFY_EN adds a read-back of
//               every successful write. The verify read compares the read-back
//               value with the written payload.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1       system clock, rising edge
//   reset            in   1       synchronous active-high reset
//   cmd_valid        in   1       command present
//   cmd_ready        out  1       command accepted when cmd_valid & cmd_ready
//   cmd_write        in   1       1 = write, 0 = read
//   cmd_address      in   ADDR_W  target word address
//   cmd_wdata        in   DATA_W  write payload
//   rsp_valid        out  1       one-cycle response strobe
//   rsp_rdata        out  DATA_W  read data (0 for writes / errors)
//   rsp_error        out  1       timeout or verify mismatch
//   avm_address      out  ADDR_W  Avalon address
//   avm_chipselect   out  1       Avalon chipselect
//   avm_write_n      out  1       Avalon write strobe, active low
//   avm_read_n       out  1       Avalon read strobe, active low
//   avm_writedata    out  32      zero-extended payload
//   avm_readdata     in   32      low DATA_W bits used
//   avm_waitrequest  in   1       slave stall
// ============================================================================
module avalon_pio_master #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 18,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WR   = 3'd1;
    localparam logic [2:0] c_ST_RD   = 3'd2;
    localparam logic [2:0] c_ST_LAT  = 3'd3;
    localparam logic [2:0] c_ST_RSP  = 3'd4;
`ifdef PIO_READBACK_VERIFY_EN
    localparam logic [2:0] c_ST_VRD  = 3'd5;
    localparam logic [2:0] c_ST_VLAT = 3'd6;
`endif

    // Value the stall counter holds during the final tolerated stall cycle.
    localparam logic [15:0] c_STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    // Value the latency counter holds during the final latency cycle.
    localparam logic [2:0]  c_LAT_LAST   = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [15:0]       r_stall;
    logic [2:0]        r_lat;
    logic              r_avm_chipselect;
    logic              r_avm_write_n;
    logic              r_avm_read_n;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_error;

    logic              w_accept;
    logic              w_timeout;
    logic              w_rd_done;
    logic              w_cs_d;
    logic              w_write_n_d;
    logic              w_read_n_d;
    logic              w_rsp_valid_d;
    logic [DATA_W-1:0] w_rsp_rdata_d;
    logic              w_rsp_error_d;
`ifdef PIO_READBACK_VERIFY_EN
    logic              w_verify_done;
`endif
    logic              w_unused_readdata;

    assign cmd_ready = (r_state == c_ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Upper readdata bits are intentionally ignored.
    assign w_unused_readdata = ^avm_readdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_rd_done    = 1'b0;
`ifdef PIO_READBACK_VERIFY_EN
        w_verify_done = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = cmd_write ? c_ST_WR : c_ST_RD;
                end
            end
            c_ST_WR: begin
                if (!avm_waitrequest) begin
`ifdef PIO_READBACK_VERIFY_EN
                    w_next_state = c_ST_VRD;
`else
                    w_next_state = c_ST_RSP;
`endif
                end else if (r_stall == c_STALL_LAST) begin
                    w_next_state = c_ST_RSP;
                    w_timeout    = 1'b1;
                end
            end
            c_ST_RD: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        w_next_state = c_ST_RSP;
                        w_rd_done    = 1'b1;
                    end else begin
                        w_next_state = c_ST_LAT;
                    end
                end else if (r_stall == c_STALL_LAST) begin
                    w_next_state = c_ST_RSP;
                    w_timeout    = 1'b1;
                end
            end
            c_ST_LAT: begin
                if (r_lat == c_LAT_LAST) begin
                    w_next_state = c_ST_RSP;
                    w_rd_done    = 1'b1;
                end
            end
`ifdef PIO_READBACK_VERIFY_EN
            // The first VRD cycle has strobes low, giving the mandatory idle
            // strobe cycle between the write and its read-back.
            c_ST_VRD: begin
                if (r_avm_chipselect) begin
                    if (!avm_waitrequest) begin
                        if (READ_LATENCY == 0) begin
                            w_next_state  = c_ST_RSP;
                            w_rd_done     = 1'b1;
                            w_verify_done = 1'b1;
                        end else begin
                            w_next_state = c_ST_VLAT;
                        end
                    end else if (r_stall == c_STALL_LAST) begin
                        w_next_state = c_ST_RSP;
                        w_timeout    = 1'b1;
                    end
                end
            end
            c_ST_VLAT: begin
                if (r_lat == c_LAT_LAST) begin
                    w_next_state  = c_ST_RSP;
                    w_rd_done     = 1'b1;
                    w_verify_done = 1'b1;
                end
            end
`endif
            c_ST_RSP: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values computed from the next state so that every
    // Avalon and response output comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_d        = 1'b0;
        w_write_n_d   = 1'b1;
        w_read_n_d    = 1'b1;
        w_rsp_valid_d = 1'b0;
        w_rsp_rdata_d = '0;
        w_rsp_error_d = 1'b0;
        case (w_next_state)
            c_ST_WR: begin
                w_cs_d      = 1'b1;
                w_write_n_d = 1'b0;
            end
            c_ST_RD: begin
                w_cs_d     = 1'b1;
                w_read_n_d = 1'b0;
            end
`ifdef PIO_READBACK_VERIFY_EN
            c_ST_VRD: begin
                if (r_state == c_ST_VRD) begin
                    w_cs_d     = 1'b1;
                    w_read_n_d = 1'b0;
                end
            end
`endif
            c_ST_RSP: begin
                w_rsp_valid_d = 1'b1;
                w_rsp_error_d = w_timeout;
                if (w_rd_done) begin
                    w_rsp_rdata_d = avm_readdata[DATA_W-1:0];
                end
`ifdef PIO_READBACK_VERIFY_EN
                if (w_verify_done && (avm_readdata[DATA_W-1:0] != r_wdata)) begin
                    w_rsp_error_d = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr           <= '0;
            r_wdata          <= '0;
            r_stall          <= '0;
            r_lat            <= '0;
            r_avm_chipselect <= 1'b0;
            r_avm_write_n    <= 1'b1;
            r_avm_read_n     <= 1'b1;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_error      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= cmd_address;
                r_wdata <= cmd_wdata;
            end
            // Both counters restart on every state change; stalls only count
            // while a strobe is actually on the bus.
            if (w_next_state != r_state) begin
                r_stall <= '0;
                r_lat   <= '0;
            end else begin
                if (r_avm_chipselect && avm_waitrequest) begin
                    r_stall <= r_stall + 16'd1;
                end
                r_lat <= r_lat + 3'd1;
            end
            r_avm_chipselect <= w_cs_d;
            r_avm_write_n    <= w_write_n_d;
            r_avm_read_n     <= w_read_n_d;
            r_rsp_valid      <= w_rsp_valid_d;
            r_rsp_rdata      <= w_rsp_rdata_d;
            r_rsp_error      <= w_rsp_error_d;
        end
    end

    assign avm_address    = r_addr;
    assign avm_writedata  = {{(32-DATA_W){1'b0}}, r_wdata};
    assign avm_chipselect = r_avm_chipselect;
    assign avm_write_n    = r_avm_write_n;
    assign avm_read_n     = r_avm_read_n;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_error      = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_avalon_pio_master
// Description : Directed, table-driven bench for avalon_pio_master. One
//               instance uses READ_LATENCY=0 and one uses READ_LATENCY=2;
//               both use TIMEOUT_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_master;

    localparam int c_TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Instance with READ_LATENCY = 0
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_address;
    logic [17:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [17:0] rsp_rdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n, avm_read_n, avm_waitrequest;
    logic [31:0] avm_writedata, avm_readdata;

    // Instance with READ_LATENCY = 2
    logic        l2_cmd_valid, l2_cmd_ready, l2_cmd_write;
    logic [1:0]  l2_cmd_address;
    logic [17:0] l2_cmd_wdata;
    logic        l2_rsp_valid, l2_rsp_error;
    logic [17:0] l2_rsp_rdata;
    logic [1:0]  l2_avm_address;
    logic        l2_avm_chipselect, l2_avm_write_n, l2_avm_read_n, l2_avm_waitrequest;
    logic [31:0] l2_avm_writedata, l2_avm_readdata;

    avalon_pio_master #(.ADDR_W(2), .DATA_W(18), .READ_LATENCY(0), .TIMEOUT_CYCLES(c_TMO)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    avalon_pio_master #(.ADDR_W(2), .DATA_W(18), .READ_LATENCY(2), .TIMEOUT_CYCLES(c_TMO)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .cmd_valid(l2_cmd_valid), .cmd_ready(l2_cmd_ready), .cmd_write(l2_cmd_write),
        .cmd_address(l2_cmd_address), .cmd_wdata(l2_cmd_wdata),
        .rsp_valid(l2_rsp_valid), .rsp_rdata(l2_rsp_rdata), .rsp_error(l2_rsp_error),
        .avm_address(l2_avm_address), .avm_chipselect(l2_avm_chipselect),
        .avm_write_n(l2_avm_write_n), .avm_read_n(l2_avm_read_n),
        .avm_writedata(l2_avm_writedata), .avm_readdata(l2_avm_readdata),
        .avm_waitrequest(l2_avm_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [17:0] wdata;
        logic [31:0] slave_rdata;   // value the slave presents on readdata
        int          stall;         // strobe cycles with waitrequest=1
        int          exp_strobes;   // cycles with chipselect high
        int          exp_rsp_cyc;   // cycle of rsp_valid, accept edge = cycle 0
        logic [17:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   cyc;
        int   strobes;
        int   rsp_cyc;
        logic got;
        logic got_err;
        logic [17:0] got_rdata;
        logic bad_field, bad_type, bad_ready;
        e = v;
`ifdef PIO_READBACK_VERIFY_EN
        if (e.wr && e.stall < c_TMO) begin
            e.exp_strobes = e.exp_strobes + 1;
            e.exp_rsp_cyc = e.exp_rsp_cyc + 2;
            e.exp_rdata   = e.slave_rdata[17:0];
            e.exp_err     = (e.slave_rdata[17:0] != e.wdata);
        end
`endif
        check($sformatf("v%0d_idle_ready", idx), 32'(cmd_ready), 32'd1);
        cmd_valid       = 1'b1;
        cmd_write       = e.wr;
        cmd_address     = e.addr;
        cmd_wdata       = e.wdata;
        avm_readdata    = e.slave_rdata;
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        // Requester keeps cmd_valid high with different fields while busy.
        cmd_write   = ~e.wr;
        cmd_address = ~e.addr;
        cmd_wdata   = ~e.wdata;
        cyc = 1; strobes = 0; rsp_cyc = -1; got = 1'b0;
        got_err = 1'b0; got_rdata = '0;
        bad_field = 1'b0; bad_type = 1'b0; bad_ready = 1'b0;
        while (!got && cyc <= 40) begin
            if (cmd_ready) bad_ready = 1'b1;
            if (avm_chipselect) begin
                strobes++;
                if (avm_address !== e.addr) bad_field = 1'b1;
                if (e.wr && avm_writedata !== {14'd0, e.wdata}) bad_field = 1'b1;
                if (!avm_write_n && !avm_read_n) bad_type = 1'b1;
                if (strobes == 1 && (avm_write_n !== !e.wr || avm_read_n !== e.wr)) bad_type = 1'b1;
                avm_waitrequest = (strobes <= e.stall);
            end else begin
                if (!avm_write_n || !avm_read_n) bad_type = 1'b1;
                avm_waitrequest = 1'b0;
            end
            if (rsp_valid) begin
                got       = 1'b1;
                rsp_cyc   = cyc;
                got_rdata = rsp_rdata;
                got_err   = rsp_error;
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        check($sformatf("v%0d_rsp_cycle", idx), 32'(rsp_cyc), 32'(e.exp_rsp_cyc));
        check($sformatf("v%0d_rdata", idx), 32'(got_rdata), 32'(e.exp_rdata));
        check($sformatf("v%0d_error", idx), 32'(got_err), 32'(e.exp_err));
        check($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'(e.exp_strobes));
        check($sformatf("v%0d_addr_data_stable", idx), 32'(bad_field), 32'd0);
        check($sformatf("v%0d_strobe_type", idx), 32'(bad_type), 32'd0);
        check($sformatf("v%0d_busy_not_ready", idx), 32'(bad_ready), 32'd0);
        check($sformatf("v%0d_rsp_one_cycle", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_ready_after", idx), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        l2_cmd_valid = 1'b0; l2_cmd_write = 1'b0; l2_cmd_address = '0; l2_cmd_wdata = '0;
        l2_avm_readdata = '0; l2_avm_waitrequest = 1'b0;

        //             wr    addr   wdata       slave_rdata   stall strb rsp rdata      err
        vecs[0] = '{1'b1, 2'd0, 18'h2ABCD, 32'h0002ABCD, 0,  1,   2, 18'h00000, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 18'h00000, 32'hFFF3FFFF, 0,  1,   2, 18'h3FFFF, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 18'h3FFFF, 32'hFFFFFFFF, 3,  4,   5, 18'h00000, 1'b0};
        vecs[3] = '{1'b0, 2'd2, 18'h00000, 32'h00012345, 2,  3,   4, 18'h12345, 1'b0};
        vecs[4] = '{1'b1, 2'd1, 18'h00001, 32'h00000001, 99, 8,   9, 18'h00000, 1'b1};
        vecs[5] = '{1'b0, 2'd1, 18'h00000, 32'hFFFFFFFF, 99, 8,   9, 18'h00000, 1'b1};
        vecs[6] = '{1'b1, 2'd2, 18'h00155, 32'h00000154, 0,  1,   2, 18'h00000, 1'b0};
        vecs[7] = '{1'b0, 2'd3, 18'h3FFFF, 32'h00000000, 0,  1,   2, 18'h00000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_chipselect", 32'(avm_chipselect), 32'd0);
        check("rst_write_n", 32'(avm_write_n), 32'd1);
        check("rst_read_n", 32'(avm_read_n), 32'd1);
        check("rst_address", 32'(avm_address), 32'd0);
        check("rst_writedata", avm_writedata, 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_error, rsp_rdata}), 32'd0);
        check("rst_l2_chipselect", 32'(l2_avm_chipselect), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during a stalled read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2;
        avm_waitrequest = 1'b1; avm_readdata = 32'h0003AAAA;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pre_cs", 32'(avm_chipselect), 32'd1);
        check("mid_rst_pre_rd_n", 32'(avm_read_n), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        check("mid_rst_rd_n", 32'(avm_read_n), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || avm_chipselect) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);

        // READ_LATENCY = 2: readdata is only valid at the last latency edge
        l2_avm_readdata = 32'h0001FFFF;
        l2_cmd_valid = 1'b1; l2_cmd_write = 1'b0; l2_cmd_address = 2'd1;
        @(posedge clk); #1;
        l2_cmd_valid = 1'b0;
        check("l2_c1_strobe", 32'({l2_avm_chipselect, l2_avm_read_n, l2_avm_write_n}), 32'b101);
        check("l2_c1_addr", 32'(l2_avm_address), 32'd1);
        @(posedge clk); #1;
        check("l2_c2_strobe_off", 32'({l2_avm_chipselect, l2_avm_read_n}), 32'b01);
        check("l2_c2_rsp", 32'(l2_rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("l2_c3_rsp", 32'(l2_rsp_valid), 32'd0);
        l2_avm_readdata = 32'hFFF21234;
        @(posedge clk); #1;
        l2_avm_readdata = 32'h0001FFFF;
        check("l2_c4_rsp_valid", 32'(l2_rsp_valid), 32'd1);
        check("l2_c4_rdata", 32'(l2_rsp_rdata), 32'h21234);
        check("l2_c4_err", 32'(l2_rsp_error), 32'd0);
        @(posedge clk); #1;
        check("l2_c5_rsp_off", 32'(l2_rsp_valid), 32'd0);
        check("l2_c5_ready", 32'(l2_cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
